// File: rtl/xbar_feed_ctrl.sv
// xbar_feed_ctrl: buffers input vectors and issues one stationary then N streaming vectors with mux selects to the xbar
// Optional feature macro: XBAR_FEED_STALL_EN (adds i_stall, which holds pops while high)
// Ports:
//   clk, rst (async active-low)
//   i_start, i_num_stream, i_stat_mux, i_stream_mux : sequence launch and captured configuration
//   i_wr_valid, i_wr_data, o_wr_ready              : vector FIFO write side
//   o_data_bus, o_mux_bus, o_valid                  : registered xbar feed, zero when nothing is issued
//   o_busy, o_done                                  : sequencer status
module xbar_feed_ctrl #(
  parameter int DATA_TYPE  = 16,
  parameter int NUM_PES    = 16,
  parameter int INPUT_BW   = 16,
  parameter int LOG2_PES   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LOG2_DEPTH = 2,
  parameter int CNT_W      = 11
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef XBAR_FEED_STALL_EN
  input  logic                         i_stall,
`endif
  input  logic                         i_start,
  input  logic [CNT_W-1:0]             i_num_stream,
  input  logic [LOG2_PES*NUM_PES-1:0]  i_stat_mux,
  input  logic [LOG2_PES*NUM_PES-1:0]  i_stream_mux,
  input  logic                         i_wr_valid,
  input  logic [INPUT_BW*DATA_TYPE-1:0] i_wr_data,
  output logic                         o_wr_ready,
  output logic [INPUT_BW*DATA_TYPE-1:0] o_data_bus,
  output logic [LOG2_PES*NUM_PES-1:0]  o_mux_bus,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int DW = INPUT_BW * DATA_TYPE;
  localparam int MW = LOG2_PES * NUM_PES;
  typedef enum logic [1:0] {IDLE, STAT, STREAM, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG2_DEPTH:0] count;
  logic [CNT_W-1:0] remain;
  logic [MW-1:0] stat_mux, stream_mux;
  logic push, pop, stall;
`ifdef XBAR_FEED_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif
  assign o_wr_ready = count != (LOG2_DEPTH+1)'(FIFO_DEPTH);
  assign push = i_wr_valid && o_wr_ready;
  // count is checked before this cycle's push, so a freshly written vector is never popped in the same cycle
  assign pop = (state == STAT || state == STREAM) && count != '0 && !stall;
  assign o_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = i_start ? STAT : IDLE;
      STAT:    state_nx = pop ? (remain == '0 ? DONE : STREAM) : STAT;
      STREAM:  state_nx = pop && remain == CNT_W'(1) ? DONE : STREAM;
      DONE:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_wr_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remain     <= '0;
      stat_mux   <= '0;
      stream_mux <= '0;
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_mux_bus  <= '0;
      o_done     <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
      if (state == IDLE && i_start) begin
        remain     <= i_num_stream;
        stat_mux   <= i_stat_mux;
        stream_mux <= i_stream_mux;
      end else if (state == STREAM && pop) begin
        remain <= remain - 1'b1;
      end
      o_valid    <= pop;
      o_data_bus <= pop ? mem[rd_ptr] : '0;
      o_mux_bus  <= pop ? (state == STAT ? stat_mux : stream_mux) : '0;
      // registered so the pulse lands the cycle after the last issued vector
      o_done     <= state == DONE;
    end
endmodule

// File: tb/tb_xbar_feed_ctrl.sv
// tb_xbar_feed_ctrl: directed table-driven bench for xbar_feed_ctrl
module tb_xbar_feed_ctrl;
  localparam logic [63:0] STAT_M   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] STREAM_M = 64'hFEDC_FEDC_FEDC_FEDC;
  logic clk, rst, i_start, i_wr_valid, o_wr_ready, o_valid, o_busy, o_done;
  logic [10:0] i_num_stream;
  logic [63:0] i_stat_mux, i_stream_mux, o_mux_bus;
  logic [255:0] i_wr_data, o_data_bus;
`ifdef XBAR_FEED_STALL_EN
  logic i_stall;
`endif
  int checks = 0, errors = 0;
  xbar_feed_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef XBAR_FEED_STALL_EN
    .i_stall(i_stall),
`endif
    .i_start(i_start), .i_num_stream(i_num_stream), .i_stat_mux(i_stat_mux),
    .i_stream_mux(i_stream_mux), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_data_bus(o_data_bus), .o_mux_bus(o_mux_bus),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t required=completion", $time);
    $fatal(1);
  end
  typedef struct {
    bit st; int num; bit wv; int wk;
    bit rdy; bit vld; int dk; int ms; bit bsy; bit dn;
  } row_t;
  row_t tbl[$];
  function automatic row_t r(bit st, int num, bit wv, int wk, bit rdy, bit vld, int dk, int ms, bit bsy, bit dn);
    row_t x;
    x.st = st; x.num = num; x.wv = wv; x.wk = wk;
    x.rdy = rdy; x.vld = vld; x.dk = dk; x.ms = ms; x.bsy = bsy; x.dn = dn;
    return x;
  endfunction
  function automatic logic [255:0] vec(int k);
    logic [255:0] v;
    for (int j = 0; j < 16; j++) v[j*16 +: 16] = 16'(k * 256 + j);
    return v;
  endfunction
  function automatic logic [399:0] pk(logic rdy, logic vld, logic [255:0] d, logic [63:0] m, logic bsy, logic dn);
    return 400'({rdy, vld, d, m, bsy, dn});
  endfunction
  function automatic logic [399:0] expv(logic rdy, logic vld, int dk, int ms, logic bsy, logic dn);
    return pk(rdy, vld, dk != 0 ? vec(dk) : '0, ms == 1 ? STAT_M : ms == 2 ? STREAM_M : '0, bsy, dn);
  endfunction
  function automatic logic [399:0] act();
    return pk(o_wr_ready, o_valid, o_data_bus, o_mux_bus, o_busy, o_done);
  endfunction
  task automatic chk(string name, logic [399:0] a, logic [399:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [255:0] q[$];
  int acc, pops, dones, k;
  initial begin
    rst = 0; i_start = 0; i_num_stream = '0; i_stat_mux = '0; i_stream_mux = '0;
    i_wr_valid = 0; i_wr_data = '0;
`ifdef XBAR_FEED_STALL_EN
    i_stall = 0;
`endif
    repeat (3) tick();
    chk("reset_held", act(), expv(1, 0, 0, 0, 0, 0));
    rst = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle", act(), expv(1, 0, 0, 0, 0, 0));
    end
    tbl.push_back(r(0,0,1,1, 1,0,0,0,0,0));
    tbl.push_back(r(0,0,1,2, 1,0,0,0,0,0));
    tbl.push_back(r(0,0,1,3, 1,0,0,0,0,0));
    tbl.push_back(r(0,0,1,4, 0,0,0,0,0,0));
    tbl.push_back(r(1,3,0,0, 0,0,0,0,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,1,1,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,2,2,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,3,2,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,4,2,1,0));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(r(0,0,1,5, 1,0,0,0,0,0));
    tbl.push_back(r(1,2,0,0, 1,0,0,0,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,5,1,1,0));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,1,0));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,1,0));
    tbl.push_back(r(0,0,1,6, 1,0,0,0,1,0));
    tbl.push_back(r(0,0,1,7, 1,1,6,2,1,0));
    tbl.push_back(r(0,0,0,0, 1,1,7,2,1,0));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(r(0,0,1,8, 1,0,0,0,0,0));
    tbl.push_back(r(1,0,0,0, 1,0,0,0,1,0));
    tbl.push_back(r(1,5,0,0, 1,1,8,1,1,0));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(r(0,0,0,0, 1,0,0,0,0,0));
    foreach (tbl[i]) begin
      i_start = tbl[i].st;
      i_num_stream = 11'(tbl[i].num);
      i_stat_mux = tbl[i].st ? STAT_M : '0;
      i_stream_mux = tbl[i].st ? STREAM_M : '0;
      i_wr_valid = tbl[i].wv;
      i_wr_data = tbl[i].wv ? vec(tbl[i].wk) : '0;
      tick();
      chk($sformatf("table_row%0d", i), act(), expv(tbl[i].rdy, tbl[i].vld, tbl[i].dk, tbl[i].ms, tbl[i].bsy, tbl[i].dn));
    end
    i_start = 0; i_wr_valid = 0; i_wr_data = '0;
    i_stat_mux = STAT_M; i_stream_mux = STREAM_M;
    pops = 0; dones = 0; k = 100;
    i_wr_valid = 1; i_wr_data = vec(k);
    for (int c = 0; c < 80 && !(pops == 10 && dones == 1); c++) begin
      i_start = (c == 8);
      i_num_stream = 11'd9;
      chk("wrap_ready", 400'(o_wr_ready), 400'(q.size() != 4));
      acc = int'(i_wr_valid && q.size() != 4);
      tick();
      if (o_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wrap_pop: got valid with data %h expected no valid (model empty)", o_data_bus);
        end else chk("wrap_data", 400'(o_data_bus), 400'(q.pop_front()));
        pops++;
      end
      if (acc != 0) begin
        q.push_back(vec(k));
        k++;
      end
      dones += int'(o_done);
      i_wr_valid = pops < 10;
      i_wr_data = vec(k);
    end
    i_start = 0; i_wr_valid = 0;
    chk("wrap_pops", 400'(pops), 400'(10));
    chk("wrap_dones", 400'(dones), 400'(1));
    rst = 0;
    tick();
    rst = 1;
    q.delete();
    chk("reset_flush", act(), expv(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      i_wr_valid = 1; i_wr_data = vec(200 + i);
      tick();
    end
    i_wr_valid = 0; i_start = 1; i_num_stream = 11'd3;
    tick();
    i_start = 0;
    tick();
    chk("mid_stat", act(), expv(1, 1, 200, 1, 1, 0));
    tick();
    chk("mid_stream1", act(), expv(1, 1, 201, 2, 1, 0));
    #2 rst = 0;
    #1 chk("async_reset", act(), expv(1, 0, 0, 0, 0, 0));
    repeat (2) begin
      tick();
      chk("reset_no_done", act(), expv(1, 0, 0, 0, 0, 0));
    end
    rst = 1;
    i_wr_valid = 1; i_wr_data = vec(300);
    tick();
    i_wr_valid = 0; i_start = 1; i_num_stream = 11'd0;
    tick();
    i_start = 0;
    tick();
    chk("post_reset_stat", act(), expv(1, 1, 300, 1, 1, 0));
    tick();
    chk("post_reset_done", act(), expv(1, 0, 0, 0, 0, 1));
`ifdef XBAR_FEED_STALL_EN
    for (int i = 0; i < 4; i++) begin
      i_wr_valid = 1; i_wr_data = vec(400 + i);
      tick();
    end
    i_wr_valid = 0; i_start = 1; i_num_stream = 11'd3;
    tick();
    i_start = 0;
    tick();
    chk("stall_stat", act(), expv(1, 1, 400, 1, 1, 0));
    i_stall = 1;
    repeat (3) begin
      tick();
      chk("stall_bubble", act(), expv(1, 0, 0, 0, 1, 0));
    end
    i_stall = 0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("stall_resume", act(), expv(1, 1, 400 + i, 2, 1, 0));
    end
    tick();
    chk("stall_done", act(), expv(1, 0, 0, 0, 0, 1));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_feed_ctrl.md
Name: xbar_feed_ctrl

Overview:
Feed sequencer directly upstream of the xbar distribution network. Buffers incoming data vectors in a small FIFO, then issues one stationary vector followed by N streaming vectors. Each issued vector goes out on the xbar data bus together with its per-PE mux-select pattern. Replaces the hand-driven data/select sequencing used for xbar bring-up, and provides valid/busy/done status to the top-level controller.

Parameters:
DATA_TYPE, 16, element width in bits
NUM_PES, 16, number of PEs / xbar outputs
INPUT_BW, 16, elements per input vector
LOG2_PES, 4, select width per PE
FIFO_DEPTH, 4, vector buffer entries (power of two)
LOG2_DEPTH, 2, log2(FIFO_DEPTH)
CNT_W, 11, streaming-count width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_num_stream  in  CNT_W  number of streaming vectors after the stationary one; captured on i_start
i_stat_mux  in  LOG2_PES*NUM_PES  select pattern for the stationary vector; captured on i_start
i_stream_mux  in  LOG2_PES*NUM_PES  select pattern for streaming vectors; captured on i_start
i_wr_valid  in  1  write vector valid
i_wr_data  in  INPUT_BW*DATA_TYPE  write vector
o_wr_ready  out  1  FIFO not full
o_data_bus  out  INPUT_BW*DATA_TYPE  to xbar i_data_bus
o_mux_bus  out  LOG2_PES*NUM_PES  to xbar i_mux_bus
o_valid  out  1  o_data_bus/o_mux_bus carry an issued vector this cycle
o_busy  out  1  FSM not IDLE
o_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (rst=0, async): FIFO pointers/count=0, FSM=IDLE, all outputs 0 except o_wr_ready=1, captured registers=0.
- FIFO:
  - Push when i_wr_valid && o_wr_ready; o_wr_ready = (count != FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
  - No fall-through: a vector pushed in cycle t is poppable from t+1.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - FIFO accepts pushes in every state.
- FSM states: IDLE, STAT, STREAM, DONE.
  - IDLE: on i_start, capture i_num_stream, i_stat_mux, i_stream_mux (as remaining count); go to STAT next cycle.
  - STAT: pop when FIFO non-empty. Next cycle: o_data_bus=popped vector, o_mux_bus=stat_mux, o_valid=1. After the pop: if count==0 go to DONE, else go to STREAM.
  - STREAM: pop one vector per cycle while non-empty; each issued vector uses stream_mux; decrement count on each pop. The pop that takes count to 0 moves the FSM to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
  - i_start is ignored while o_busy=1.
- Output timing:
  - Outputs are registered; latency from pop to o_valid is 1 cycle.
  - Any cycle without an issued vector: o_valid=0, o_data_bus=0, o_mux_bus=0 (xbar sees zeros, as in idle).
- Empty FIFO in STAT/STREAM: bubble cycle; count and state hold; resume on next available vector.
- o_busy=1 in STAT, STREAM, DONE.
- Reset mid-sequence: everything returns to reset values immediately. Buffered vectors are discarded. No o_done is generated.
- Arithmetic: count is an unsigned CNT_W down-counter with no wrap. Max stream length is 2^CNT_W-1.

Optional Feature:
XBAR_FEED_STALL_EN
- Defined: adds input port i_stall (1 bit). While i_stall=1, no pop occurs; the next cycle has o_valid=0 and zero buses; count and state hold; FIFO pushes continue. i_stall has no effect in IDLE/DONE.
- Undefined: no i_stall port; pops are gated only by FIFO empty.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> all outputs 0, o_wr_ready=1, o_busy=0; i_wr_valid=0 for 10 cycles -> o_valid stays 0.
- Full sequence, num_stream=3: push 4 vectors {1..16 as 0x3F80..0x4180}, {0x3F80,0x40A0,0x4110,0x4150,0...}, two more; i_stat_mux=identity 0xFEDC_BA98_7654_3210, i_stream_mux=0xFEDC_FEDC_FEDC_FEDC; start -> 4 consecutive o_valid cycles; first carries identity mux, next 3 carry stream mux; data in push order; o_done 1 cycle after the last; o_busy falls with it.
- FIFO full/backpressure: no start, push 5 vectors -> o_wr_ready=0 after the 4th; 5th held until a pop; count never exceeds 4; wrap verified over 10 push/pop rounds.
- Starvation: start with num_stream=2 and only 1 vector buffered -> stationary issued, then o_valid=0 with zero buses until the next pushes; remaining 2 issue afterwards; o_done once.
- num_stream=0: start with 1 vector -> single o_valid with stat mux, o_done the next cycle; a second i_start while busy is ignored.
- Reset mid-STREAM (after 1 of 3 streaming vectors) -> outputs 0 asynchronously, FIFO empty, no o_done; new sequence runs correctly afterwards. With XBAR_FEED_STALL_EN: i_stall=1 for 3 cycles mid-stream -> 3 bubble cycles, no vector lost or duplicated.
